// File: rtl/multdiv_ctrl.sv
// Iterative signed 32x32 multiply / 32/32 divide controller.
// One shared add/subtract/shift datapath, 32 iterations per operation, registered outputs.
module multdiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MULT = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [5:0]       ITERS   = 6'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2:0]       r_state;
    logic [5:0]       r_cnt;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_neg;
    logic [WIDTH-1:0] r_result;
    logic             r_exc;
    logic             r_rdy;
    logic             r_busy;

    logic             w_start_mul;
    logic             w_start_div;
    logic             w_illegal;
    logic             w_is_div;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH+1:0] w_add_x;
    logic [WIDTH+1:0] w_add_y;
    logic [WIDTH+1:0] w_sum;
    logic [WIDTH:0]   w_mul_sel;
    logic             w_div_fits;
    logic             w_last;
    logic             w_err_last;
    logic             w_finish;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_quot;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic [WIDTH-1:0] w_fin_result;
    logic             w_fin_exc;

    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    always_comb begin
        w_start_mul = ctrl_MULT & ~ctrl_DIV;
        w_start_div = ~ctrl_MULT & ctrl_DIV;
        w_illegal   = ctrl_MULT & ctrl_DIV;
        w_is_div    = (r_state == S_DIV);
        w_a_mag     = f_abs(r_op_a);
        w_b_mag     = f_abs(r_op_b);

        // Multiply adds |A| to the high half; divide subtracts |B| from the
        // remainder shifted left by one, with the top bit acting as borrow.
        w_add_x    = w_is_div ? {1'b0, r_hi, r_lo[WIDTH-1]} : {2'b00, r_hi};
        w_add_y    = w_is_div ? ~{2'b00, w_b_mag} : {2'b00, w_a_mag};
        w_sum      = w_add_x + w_add_y + {{(WIDTH+1){1'b0}}, w_is_div};
        w_mul_sel  = r_lo[0] ? w_sum[WIDTH:0] : {1'b0, r_hi};
        w_div_fits = ~w_sum[WIDTH+1];

        w_last     = ((r_state == S_MULT) || (r_state == S_DIV)) && (r_cnt == ITERS);
        w_err_last = (r_state == S_ERR) && (r_cnt == 6'd1);
        w_finish   = w_last | w_err_last;

        w_prod     = r_neg ? (~{r_hi, r_lo} + 1'b1) : {r_hi, r_lo};
        w_quot     = r_neg ? (~r_lo + 1'b1) : r_lo;
        w_div_zero = (r_op_b == '0);
        w_div_ovf  = (r_op_a == MIN_NEG) && (r_op_b == '1);

        w_fin_result = '0;
        w_fin_exc    = 1'b1;
        if (r_state == S_DIV) begin
            w_fin_result = w_div_zero ? '0 : w_quot;
            w_fin_exc    = w_div_zero | w_div_ovf;
        end else if (r_state == S_MULT) begin
            w_fin_result = w_prod[WIDTH-1:0];
            w_fin_exc    = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            // A completing operation still reports even if a new start lands on the same edge.
            r_rdy <= w_finish;
            if (w_finish) begin
                r_result <= w_fin_result;
                r_exc    <= w_fin_exc;
            end

            if (w_illegal) begin
                r_state <= S_ERR;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
            end else if (w_start_mul | w_start_div) begin
                r_state <= w_start_mul ? S_MULT : S_DIV;
                r_cnt   <= '0;
                r_op_a  <= data_operandA;
                r_op_b  <= data_operandB;
                r_hi    <= '0;
                r_lo    <= w_start_mul ? f_abs(data_operandB) : f_abs(data_operandA);
                r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                r_busy  <= 1'b1;
            end else if (w_finish) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_MULT: begin
                        r_cnt <= r_cnt + 6'd1;
                        r_hi  <= w_mul_sel[WIDTH:1];
                        r_lo  <= {w_mul_sel[0], r_lo[WIDTH-1:1]};
                    end
                    S_DIV: begin
                        r_cnt <= r_cnt + 6'd1;
                        r_hi  <= w_div_fits ? w_sum[WIDTH-1:0] : w_add_x[WIDTH-1:0];
                        r_lo  <= {r_lo[WIDTH-2:0], w_div_fits};
                    end
                    S_ERR:   r_cnt   <= r_cnt + 6'd1;
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: vector table, reference model, and scoreboard of expected results.
module tb_multdiv_ctrl;
    localparam int OP_MUL = 0;
    localparam int OP_DIV = 1;
    localparam int OP_ILL = 2;

    typedef struct {
        int          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    exp_t q[$];

    multdiv_ctrl #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Scoreboard: every RDY pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (data_resultRDY === 1'b1) begin
            if (q.size() == 0) begin
                check("rdy_unexpected", {31'd0, data_resultRDY}, 32'd0);
            end else begin
                e = q.pop_front();
                check("result", data_result, e.res);
                check("exception", {31'd0, data_exception}, {31'd0, e.exc});
                check("rdy_latency", edge_n, e.lat);
            end
        end
    end

    function automatic void model(input int op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint p;
        if (op == OP_MUL) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            r = 32'h80000000;
            e = 1'b1;
        end else begin
            r = 32'($signed(a) / $signed(b));
            e = 1'b0;
        end
    endfunction

    // Called at a negedge; drives the start for exactly the next posedge.
    task automatic drive_start(input int op, input logic [31:0] a, input logic [31:0] b, output int t0);
        ctrl_MULT     = (op == OP_MUL) || (op == OP_ILL);
        ctrl_DIV      = (op == OP_DIV) || (op == OP_ILL);
        data_operandA = a;
        data_operandB = b;
        t0            = edge_n + 1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic idle_until(input int e);
        while (edge_n < e) begin
            @(negedge clock);
            data_operandA = $urandom;
            data_operandB = $urandom;
        end
    endtask

    task automatic check_drain();
        check("rdy_seen", q.size(), 32'd0);
        q.delete();
    endtask

    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic exc);
        int   t0;
        int   lat;
        logic busy_ok;
        drive_start(op, a, b, t0);
        lat = t0 + ((op == OP_ILL) ? 2 : 33);
        q.push_back('{res, exc, lat});
        busy_ok = 1'b1;
        while (edge_n < lat) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clock);
            data_operandA = $urandom;
            data_operandB = $urandom;
        end
        check("busy_window", {31'd0, busy_ok}, 32'd1);
        check("busy_in_rdy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        check_drain();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog edge=%0d expected=finish", edge_n);
        $fatal(1);
    end

    initial begin : stim
        vec_t        tbl[16];
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rr;
        logic        re;
        int          t0;
        int          t1;

        tbl[0]  = '{OP_MUL, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
        tbl[1]  = '{OP_MUL, 32'h00010000,   32'h00010000, 32'h00000000, 1'b1};
        tbl[2]  = '{OP_MUL, 32'hFFFFFFFF,   32'h80000000, 32'h80000000, 1'b1};
        tbl[3]  = '{OP_MUL, 32'h00001234,   32'h00000010, 32'h00012340, 1'b0};
        tbl[4]  = '{OP_MUL, 32'h80000000,   32'h00000001, 32'h80000000, 1'b0};
        tbl[5]  = '{OP_MUL, 32'hFFFF0000,   32'h00008000, 32'h80000000, 1'b0};
        tbl[6]  = '{OP_MUL, 32'h00000000,   32'h12345678, 32'h00000000, 1'b0};
        tbl[7]  = '{OP_DIV, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 1'b0};
        tbl[8]  = '{OP_DIV, 32'd5,          32'd0,        32'h00000000, 1'b1};
        tbl[9]  = '{OP_DIV, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1};
        tbl[10] = '{OP_DIV, 32'd100,        32'd7,        32'd14,       1'b0};
        tbl[11] = '{OP_DIV, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
        tbl[12] = '{OP_DIV, 32'h80000000,   32'd1,        32'h80000000, 1'b0};
        tbl[13] = '{OP_DIV, 32'd3,          32'd10,       32'd0,        1'b0};
        tbl[14] = '{OP_DIV, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       1'b0};
        tbl[15] = '{OP_ILL, 32'h00000000,   32'h00000000, 32'h00000000, 1'b1};

        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        check("reset_result", data_result, 32'd0);
        check("reset_exception", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].exc);
        end

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            model(i % 2, ra, rb, rr, re);
            run_op(i % 2, ra, rb, rr, re);
        end

        // Start on the edge that enters DONE: both operations must report.
        drive_start(OP_MUL, 32'd7, 32'hFFFFFFFD, t0);
        q.push_back('{32'hFFFFFFEB, 1'b0, t0 + 33});
        idle_until(t0 + 32);
        drive_start(OP_DIV, 32'hFFFFFFF9, 32'd2, t1);
        q.push_back('{32'hFFFFFFFD, 1'b0, t1 + 33});
        idle_until(t1 + 34);
        check_drain();

        // Abort a multiply with a divide; result holds until the next DONE.
        drive_start(OP_MUL, 32'd3, 32'd4, t0);
        idle_until(t0 + 9);
        check("result_hold", data_result, 32'hFFFFFFFD);
        drive_start(OP_DIV, 32'd100, 32'd7, t1);
        q.push_back('{32'd14, 1'b0, t1 + 33});
        idle_until(t1 + 34);
        check_drain();

        // Illegal start takes over an operation in flight.
        drive_start(OP_MUL, 32'd9, 32'd9, t0);
        idle_until(t0 + 5);
        run_op(OP_ILL, 32'd1, 32'd2, 32'd0, 1'b1);

        run_op(OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0);

        // Reset mid-multiply drops it silently, then an illegal start reports.
        drive_start(OP_MUL, 32'd3, 32'd4, t0);
        idle_until(t0 + 19);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check("midreset_result", data_result, 32'd0);
        check("midreset_exception", {31'd0, data_exception}, 32'd0);
        check("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        idle_until(t0 + 40);
        run_op(OP_ILL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b1);

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
